// File: rtl/afifo_pkg.sv
// -----------------------------------------------------------------------------
// afifo_pkg
//   Shared definitions for the asymmetric BRAM36k asynchronous FIFO read side.
//   Holds the width-ratio helpers used to size the unpacker and the FIFO
//   read latency that the read-side pop/capture pipeline is built around.
//   No ports (package).
// -----------------------------------------------------------------------------
package afifo_pkg;

  // Cycles from POP to DOUT being valid at the FIFO read port.
  localparam int AFIFO_RD_LATENCY = 1;

  // Number of narrow beats carried by one wide FIFO word.
  function automatic int afifo_ratio(input int width_in, input int width_out);
    if (width_out <= 0) return 0;
    return width_in / width_out;
  endfunction

  // A legal pairing splits the wide word into a whole number (>= 1) of beats.
  function automatic bit afifo_ratio_ok(input int width_in, input int width_out);
    return (width_out > 0) && (width_in >= width_out) &&
           ((width_in % width_out) == 0);
  endfunction

  // Width of a beat index; kept at least 1 bit so RATIO == 1 still elaborates.
  function automatic int afifo_beat_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/afifo_rd_unpack_if.sv
// -----------------------------------------------------------------------------
// afifo_rd_unpack_if
//   Bundles the FIFO read-port signals and the narrow output stream of the
//   read-side unpacker.
//   FIFO side : Empty, DOUT, Underrun_Error (into unpacker), POP (out of it)
//   Stream    : M_DATA, M_VALID, M_LAST (out), M_READY (in)
//   Status    : Words_Popped, Sticky_Underrun (out)
//   modport master : the unpacker (afifo_rd_unpack)
//   modport slave  : its environment (FIFO + downstream consumer)
// -----------------------------------------------------------------------------
interface afifo_rd_unpack_if #(
  parameter int DATA_WIDTH_IN  = 36,
  parameter int DATA_WIDTH_OUT = 9,
  parameter int CNT_WIDTH      = 16
);
  logic                      Empty;
  logic [DATA_WIDTH_IN-1:0]  DOUT;
  logic                      Underrun_Error;
  logic                      POP;
  logic [DATA_WIDTH_OUT-1:0] M_DATA;
  logic                      M_VALID;
  logic                      M_READY;
  logic                      M_LAST;
  logic [CNT_WIDTH-1:0]      Words_Popped;
  logic                      Sticky_Underrun;

  modport master (
    input  Empty, DOUT, Underrun_Error, M_READY,
    output POP, M_DATA, M_VALID, M_LAST, Words_Popped, Sticky_Underrun
  );

  modport slave (
    output Empty, DOUT, Underrun_Error, M_READY,
    input  POP, M_DATA, M_VALID, M_LAST, Words_Popped, Sticky_Underrun
  );
endinterface

// File: rtl/afifo_skid2.sv
// -----------------------------------------------------------------------------
// afifo_skid2
//   Two-entry register buffer holding wide FIFO words between capture and
//   unpacking. Entries leave in arrival order.
//   clk       : clock
//   rst       : synchronous active-high reset, empties the buffer
//   push      : write push_data at the tail
//   push_data : word to store
//   pop       : remove the head entry (only when occ != 0)
//   occ       : number of valid entries, 0..2
//   head      : oldest entry (don't-care when occ == 0)
//   The caller guarantees no push when full unless it pops in the same cycle.
// -----------------------------------------------------------------------------
module afifo_skid2 #(
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [1:0]       occ_q,  occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; the queue shifts by one.
        if (occ_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Only the occupancy is reset; stale data behind occ is never observed.
  always_ff @(posedge clk) begin
    if (rst) occ_q <= 2'd0;
    else     occ_q <= occ_d;
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign occ  = occ_q;
  assign head = head_q;

endmodule

// File: rtl/afifo_rd_unpack.sv
// -----------------------------------------------------------------------------
// afifo_rd_unpack
//   Read-side consumer for the asymmetric asynchronous FIFO, entirely in the
//   FIFO read clock domain. Pops words while there is room, captures DOUT one
//   cycle after each pop into a 2-entry buffer, and streams each word out as
//   RATIO narrow beats, least-significant slice first.
//   clock0     : FIFO read clock
//   Sync_Flush : synchronous active-high reset (same net flushes the FIFO)
//   bus        : afifo_rd_unpack_if.master
//                Empty/DOUT/Underrun_Error in, POP out (FIFO read port)
//                M_DATA/M_VALID/M_LAST out, M_READY in (beat stream)
//                Words_Popped, Sticky_Underrun out (status)
// -----------------------------------------------------------------------------
module afifo_rd_unpack
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 36,
  parameter int DATA_WIDTH_OUT = 9,
  parameter int CNT_WIDTH      = 16
) (
  input  logic              clock0,
  input  logic              Sync_Flush,
  afifo_rd_unpack_if.master bus
);

  localparam int                RATIO     = afifo_ratio(DATA_WIDTH_IN, DATA_WIDTH_OUT);
  localparam int                BEAT_W    = afifo_beat_w(RATIO);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  if (!afifo_ratio_ok(DATA_WIDTH_IN, DATA_WIDTH_OUT)) begin : g_bad_ratio
    $fatal(1, "afifo_rd_unpack: DATA_WIDTH_IN (%0d) is not a whole multiple of DATA_WIDTH_OUT (%0d)",
           DATA_WIDTH_IN, DATA_WIDTH_OUT);
  end

  // The single in-flight flag below assumes DOUT arrives exactly one cycle
  // after POP.
  if (AFIFO_RD_LATENCY != 1) begin : g_bad_latency
    $fatal(1, "afifo_rd_unpack: only a 1-cycle FIFO read latency is handled");
  end

  logic [1:0]                occ;
  logic [DATA_WIDTH_IN-1:0]  head;
  logic [DATA_WIDTH_OUT-1:0] m_data;

  logic                      inflight_q, inflight_d;
  logic [BEAT_W-1:0]         beat_q,     beat_d;
  logic [CNT_WIDTH-1:0]      words_q,    words_d;
  logic                      sticky_q,   sticky_d;

  logic                      m_valid;
  logic                      m_last;
  logic                      accept;
  logic                      retire;
  logic [1:0]                fill;
  logic                      pop;

  afifo_skid2 #(
    .WIDTH (DATA_WIDTH_IN)
  ) u_skid (
    .clk       (clock0),
    .rst       (Sync_Flush),
    .push      (inflight_q),
    .push_data (bus.DOUT),
    .pop       (retire),
    .occ       (occ),
    .head      (head)
  );

  // Beat select: RATIO == 1 passes the word straight through, which also
  // keeps the indexed select from ever reaching past the word.
  if (RATIO == 1) begin : g_ratio1
    assign m_data = head[DATA_WIDTH_OUT-1:0];
  end else begin : g_ration
    assign m_data = head[beat_q * DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
  end

  always_comb begin
    m_valid = (occ != 2'd0);
    m_last  = (beat_q == LAST_BEAT);
    accept  = m_valid & bus.M_READY;
    retire  = accept & m_last;

    // Words held plus the one landing this cycle. Popping at 2 is only safe
    // when the head leaves this cycle; that term is what sustains one word
    // per cycle at RATIO == 1.
    fill = occ + {1'b0, inflight_q};
    pop  = ~bus.Empty & ~Sync_Flush &
           ((fill < 2'd2) | ((fill == 2'd2) & retire));

    inflight_d = pop;

    beat_d = beat_q;
    if (accept) beat_d = m_last ? '0 : beat_q + BEAT_W'(1);

    words_d = words_q;
    if (pop) words_d = words_q + CNT_WIDTH'(1);

    sticky_d = sticky_q | bus.Underrun_Error;
  end

  // A flush drops the in-flight flag, so a DOUT already on its way is never
  // captured.
  always_ff @(posedge clock0) begin
    if (Sync_Flush) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
      words_q    <= '0;
      sticky_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      words_q    <= words_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus.POP             = pop;
  assign bus.M_DATA          = m_data;
  assign bus.M_VALID         = m_valid;
  assign bus.M_LAST          = m_last;
  assign bus.Words_Popped    = words_q;
  assign bus.Sticky_Underrun = sticky_q;

endmodule

// File: tb/tb_afifo_rd_unpack.sv
// -----------------------------------------------------------------------------
// tb_afifo_rd_unpack
//   Drives two unpackers (36->9 and 36->36) from a queue-based FIFO model and
//   checks the beat stream against a list of expected beats built when each
//   word is written into the FIFO.
// -----------------------------------------------------------------------------
module tb_afifo_rd_unpack;

  typedef struct {
    logic [35:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic       rdy;
    logic       pop;
    logic       vld;
    logic [8:0] data;
    logic       last;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic flush9;
  logic flush36;

  afifo_rd_unpack_if #(.DATA_WIDTH_IN(36), .DATA_WIDTH_OUT(9),  .CNT_WIDTH(16)) b9 ();
  afifo_rd_unpack_if #(.DATA_WIDTH_IN(36), .DATA_WIDTH_OUT(36), .CNT_WIDTH(16)) b36 ();

  afifo_rd_unpack #(.DATA_WIDTH_IN(36), .DATA_WIDTH_OUT(9), .CNT_WIDTH(16)) dut9 (
    .clock0     (clk),
    .Sync_Flush (flush9),
    .bus        (b9)
  );

  afifo_rd_unpack #(.DATA_WIDTH_IN(36), .DATA_WIDTH_OUT(36), .CNT_WIDTH(16)) dut36 (
    .clock0     (clk),
    .Sync_Flush (flush36),
    .bus        (b36)
  );

  int checks = 0;
  int errors = 0;

  logic [35:0] q9[$];
  logic [35:0] q36[$];
  beat_t       exp9[$];
  beat_t       exp36[$];
  int          pushed9 = 0;

  logic        pop9_s, pop36_s;
  int          pop_empty_viol = 0;
  logic        stalled9 = 1'b0;
  logic [8:0]  prev_data9;
  logic        prev_last9;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push9(input logic [35:0] w);
    beat_t b;
    q9.push_back(w);
    pushed9++;
    for (int k = 0; k < 4; k++) begin
      b.data = 36'(w[k*9 +: 9]);
      b.last = (k == 3);
      exp9.push_back(b);
    end
  endtask

  task automatic push36(input logic [35:0] w);
    beat_t b;
    q36.push_back(w);
    b.data = w;
    b.last = 1'b1;
    exp36.push_back(b);
  endtask

  function automatic logic [35:0] rand36();
    return {4'($urandom()), $urandom()};
  endfunction

  // Negative-edge sampling: stream scoreboard, stall stability, pop legality.
  task automatic half_neg();
    beat_t e;
    @(negedge clk);
    pop9_s  = b9.POP;
    pop36_s = b36.POP;
    if ((b9.POP === 1'b1 && b9.Empty === 1'b1) || (b36.POP === 1'b1 && b36.Empty === 1'b1))
      pop_empty_viol++;

    if (stalled9) begin
      chk("stall_valid9", 64'(b9.M_VALID), 64'd1);
      chk("stall_data9",  64'(b9.M_DATA),  64'(prev_data9));
      chk("stall_last9",  64'(b9.M_LAST),  64'(prev_last9));
    end
    stalled9   = (b9.M_VALID === 1'b1) && (b9.M_READY === 1'b0) && !flush9;
    prev_data9 = b9.M_DATA;
    prev_last9 = b9.M_LAST;

    if (b9.M_VALID === 1'b1 && b9.M_READY === 1'b1 && !flush9) begin
      if (exp9.size() == 0) begin
        chk("extra_beat9", 64'(b9.M_DATA), 64'h0dead);
      end else begin
        e = exp9.pop_front();
        chk("beat_data9", 64'(b9.M_DATA), 64'(e.data[8:0]));
        chk("beat_last9", 64'(b9.M_LAST), 64'(e.last));
      end
    end

    if (b36.M_VALID === 1'b1 && b36.M_READY === 1'b1 && !flush36) begin
      if (exp36.size() == 0) begin
        chk("extra_beat36", 64'(b36.M_DATA), 64'h0dead);
      end else begin
        e = exp36.pop_front();
        chk("beat_data36", 64'(b36.M_DATA), 64'(e.data));
      end
    end
  endtask

  // FIFO model: pops at the clock edge, DOUT valid next cycle, Empty is a
  // registered flag updated at the same edge that consumes the last word.
  task automatic half_pos();
    @(posedge clk);
    if (pop9_s && q9.size() != 0)   b9.DOUT  <= q9.pop_front();
    if (pop36_s && q36.size() != 0) b36.DOUT <= q36.pop_front();
    b9.Empty  <= (q9.size() == 0);
    b36.Empty <= (q36.size() == 0);
    #1;
  endtask

  task automatic cycle();
    half_neg();
    half_pos();
  endtask

  task automatic drain9(input int budget, input string name);
    int n = 0;
    b9.M_READY = 1'b1;
    while ((exp9.size() != 0 || q9.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk(name, 64'(exp9.size()), 64'd0);
  endtask

  task automatic drain36(input int budget, input string name);
    int n = 0;
    b36.M_READY = 1'b1;
    while ((exp36.size() != 0 || q36.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk(name, 64'(exp36.size()), 64'd0);
  endtask

  vec_t tbl[8];
  localparam logic [35:0] UNPACK_WORD = {9'h1AA, 9'h155, 9'h0FF, 9'h001};

  initial begin
    int pops, vcount, ef, first, lastc, beats, nopop;
    logic [8:0]  held;
    logic [35:0] w1, w2;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 9'h000, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 9'h001, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 9'h0FF, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 9'h155, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 9'h1AA, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b0};

    flush9 = 1'b1;  flush36 = 1'b1;
    b9.M_READY = 1'b0;  b36.M_READY = 1'b0;
    b9.Underrun_Error = 1'b0;  b36.Underrun_Error = 1'b0;
    b9.Empty = 1'b1;  b36.Empty = 1'b1;
    b9.DOUT = '0;  b36.DOUT = '0;

    // Reset held with a non-empty FIFO.
    push9(UNPACK_WORD);
    cycle();
    for (int i = 0; i < 3; i++) begin
      half_neg();
      chk("rst_pop",    64'(b9.POP),             64'd0);
      chk("rst_valid",  64'(b9.M_VALID),         64'd0);
      chk("rst_words",  64'(b9.Words_Popped),    64'd0);
      chk("rst_last",   64'(b9.M_LAST),          64'd0);
      chk("rst_sticky", 64'(b9.Sticky_Underrun), 64'd0);
      half_pos();
    end
    q9.delete();  exp9.delete();  pushed9 = 0;
    cycle();
    flush9 = 1'b0;
    cycle();

    // Unpack order and latency, one cycle per table row.
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      b9.M_READY = tbl[i].rdy;
      if (i == 0) push9(UNPACK_WORD);
      half_neg();
      if (b9.POP === 1'b1) pops++;
      chk($sformatf("tbl%0d_pop", i),   64'(b9.POP),     64'(tbl[i].pop));
      chk($sformatf("tbl%0d_valid", i), 64'(b9.M_VALID), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_last", i),  64'(b9.M_LAST),  64'(tbl[i].last));
      if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), 64'(b9.M_DATA), 64'(tbl[i].data));
      half_pos();
    end
    chk("unpack_pop_count", 64'(pops), 64'd1);
    chk("unpack_words", 64'(b9.Words_Popped), 64'd1);

    // Backpressure: 8 words queued, consumer stalled for 20 cycles.
    b9.M_READY = 1'b0;
    for (int i = 0; i < 8; i++)
      push9({9'(i*4+19), 9'(i*4+18), 9'(i*4+17), 9'(i*4+16)});
    pops = 0;
    held = '0;
    for (int i = 0; i < 20; i++) begin
      half_neg();
      if (b9.POP === 1'b1) pops++;
      if (i == 5) held = b9.M_DATA;
      if (i == 19) begin
        chk("bp_pop_stopped", 64'(b9.POP),    64'd0);
        chk("bp_data_held",   64'(b9.M_DATA), 64'(held));
        chk("bp_first_beat",  64'(held),      64'd16);
      end
      half_pos();
    end
    chk("bp_pop_count", 64'(pops), 64'd2);
    drain9(200, "bp_drain");
    chk("bp_words", 64'(b9.Words_Popped), 64'(pushed9));

    // Flush at beat 2 of a word while the next word is in flight.
    b9.M_READY = 1'b1;
    w1 = 36'h9_8765_4321;
    w2 = 36'h1_2345_6789;
    push9(w1);
    cycle();  cycle();  cycle();
    push9(w2);
    cycle();  cycle();
    flush9 = 1'b1;
    b9.M_READY = 1'b0;
    half_neg();
    chk("fl_at_beat2", 64'(b9.M_DATA), 64'(w1[26:18]));
    chk("fl_inflight", 64'(q9.size()), 64'd0);
    exp9.delete();  q9.delete();  pushed9 = 0;
    half_pos();
    flush9 = 1'b0;
    b9.M_READY = 1'b1;
    half_neg();
    chk("fl_valid", 64'(b9.M_VALID),      64'd0);
    chk("fl_last",  64'(b9.M_LAST),       64'd0);
    chk("fl_words", 64'(b9.Words_Popped), 64'd0);
    half_pos();
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      half_neg();
      if (b9.M_VALID === 1'b1) vcount++;
      half_pos();
    end
    chk("fl_no_emit", 64'(vcount), 64'd0);
    push9(36'hA_BCDE_F012);
    drain9(20, "fl_restart_drain");
    chk("fl_restart_words", 64'(b9.Words_Popped), 64'd1);

    // Sticky underrun; a flush in the same cycle wins.
    chk("ur_clear", 64'(b9.Sticky_Underrun), 64'd0);
    b9.Underrun_Error = 1'b1;
    cycle();
    b9.Underrun_Error = 1'b0;
    half_neg();
    chk("ur_set", 64'(b9.Sticky_Underrun), 64'd1);
    half_pos();
    cycle();  cycle();
    half_neg();
    chk("ur_hold", 64'(b9.Sticky_Underrun), 64'd1);
    half_pos();
    flush9 = 1'b1;
    b9.Underrun_Error = 1'b1;
    cycle();
    flush9 = 1'b0;
    b9.Underrun_Error = 1'b0;
    pushed9 = 0;
    half_neg();
    chk("ur_flush_wins", 64'(b9.Sticky_Underrun), 64'd0);
    half_pos();

    // Random traffic and random backpressure.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0 && q9.size() < 6) push9(rand36());
      b9.M_READY = ($urandom_range(0, 9) < 6);
      cycle();
    end
    drain9(400, "rand_drain");
    chk("rand_words", 64'(b9.Words_Popped), 64'(16'(pushed9)));

    // Full throughput at RATIO == 1.
    flush36 = 1'b0;
    b36.M_READY = 1'b1;
    cycle();
    for (int i = 0; i < 1024; i++) push36(rand36());
    ef = -1;  first = -1;  lastc = -1;  beats = 0;  nopop = 0;
    for (int c = 0; c < 1100; c++) begin
      half_neg();
      if (b36.Empty === 1'b0) begin
        if (ef < 0) ef = c;
        if (b36.POP !== 1'b1) nopop++;
      end
      if (b36.M_VALID === 1'b1) begin
        if (first < 0) first = c;
        lastc = c;
        beats++;
      end
      half_pos();
    end
    chk("tp_no_pop_gap",  64'(nopop),               64'd0);
    chk("tp_beats",       64'(beats),               64'd1024);
    chk("tp_contiguous",  64'(lastc - first + 1),   64'd1024);
    chk("tp_fill_delay",  64'(first - ef),          64'd2);
    chk("tp_words",       64'(b36.Words_Popped),    64'd1024);
    chk("tp_sb_empty",    64'(exp36.size()),        64'd0);

    // Counter wrap: bring Words_Popped to 0xFFFF, then one more pop.
    for (int i = 0; i < 65535 - 1024; i++) push36(rand36());
    drain36(66000, "wrap_drain");
    chk("wrap_max", 64'(b36.Words_Popped), 64'hFFFF);
    push36(rand36());
    drain36(20, "wrap_drain_last");
    chk("wrap_zero", 64'(b36.Words_Popped), 64'h0000);

    chk("pop_while_empty", 64'(pop_empty_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
